// File: rtl/jk_pkg.sv
// Shared JK flip-flop definitions for the master-slave counter slice.
package jk_pkg;

  typedef enum logic [1:0] {
    HOLD   = 2'b00,
    RESET  = 2'b01,
    SET    = 2'b10,
    TOGGLE = 2'b11
  } jk_mode_e;

  // The {J,K} bit pair maps directly onto the mode encoding.
  function automatic jk_mode_e jk_encode(input logic j, input logic k);
    return jk_mode_e'({j, k});
  endfunction

endpackage

// File: rtl/jk_ms_stage.sv
// Single-bit master-slave JK storage: master samples on the rising edge,
// slave copies the master on the falling edge.
module jk_ms_stage
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q
);

  logic m;

  // Toggle inverts the slave output, as in a classic master-slave JK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m <= 1'b0;
    end else begin
      case (jk_encode(j, k))
        HOLD:    m <= m;
        RESET:   m <= 1'b0;
        SET:     m <= 1'b1;
        TOGGLE:  m <= ~q;
        default: m <= m;
      endcase
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= m;
  end

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MOD up/down counter built from master-slave JK stages; the
// combinational block derives the next count and the per-bit J/K drive.
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  if (MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_mod
    $error("jk_mod_counter: MOD out of range 2..2**WIDTH");
  end

  localparam int unsigned      MOD_U = MOD;
  localparam logic [WIDTH-1:0] TOP   = WIDTH'(MOD_U - 1);
  localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MOD_U);

  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;

  // Illegal states (q >= MOD) fall into the up/down wrap branches.
  always_comb begin
    n = q;
    if (load) begin
      n = ({1'b0, load_val} < MOD_X) ? load_val : TOP;
    end else if (en) begin
      if (up) n = (q >= TOP) ? '0 : q + WIDTH'(1);
      else    n = (q == '0 || {1'b0, q} >= MOD_X) ? TOP : q - WIDTH'(1);
    end
    // Load uses set/reset drive; count and hold use toggle drive.
    j_vec = load ? n  : (q ^ n);
    k_vec = load ? ~n : (q ^ n);
  end

  assign tc = en & ((up & (q == TOP)) | (~up & (q == '0)));

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    jk_ms_stage u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .j     (j_vec[i]),
      .k     (k_vec[i]),
      .q     (q[i])
    );
  end

endmodule

// File: tb/tb_jk_mod_counter.sv
// Self-checking bench for jk_mod_counter (decade default) plus a two-digit cascade.
module tb_jk_mod_counter;

  localparam int MOD = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, up = 1'b0, load = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] q;
  logic       tc;

  logic       cas_en = 1'b0;
  logic [3:0] units_q, tens_q;
  logic       units_tc, tens_tc;

  int vectors = 0;
  int miscompares = 0;
  int m_q = 0;

  jk_mod_counter #(.WIDTH(4), .MOD(MOD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
    .load_val(load_val), .q(q), .tc(tc)
  );

  jk_mod_counter #(.WIDTH(4), .MOD(MOD)) u_units (
    .clk(clk), .rst_n(rst_n), .en(cas_en), .up(1'b1), .load(1'b0),
    .load_val(4'd0), .q(units_q), .tc(units_tc)
  );

  jk_mod_counter #(.WIDTH(4), .MOD(MOD)) u_tens (
    .clk(clk), .rst_n(rst_n), .en(units_tc), .up(1'b1), .load(1'b0),
    .load_val(4'd0), .q(tens_q), .tc(tens_tc)
  );

  always #5 clk = ~clk;

  task automatic check(input logic [7:0] obs, input logic [7:0] exp, input string tag);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Entered and left 1 time unit after a falling edge.
  task automatic step(input logic e, input logic u, input logic l,
                      input logic [3:0] lv, input string tag);
    int exp_tc;
    en = e; up = u; load = l; load_val = lv;
    #1;
    exp_tc = (e && ((u && m_q == MOD - 1) || (!u && m_q == 0))) ? 1 : 0;
    check({7'd0, tc}, 8'(exp_tc), {tag, "_tc"});
    @(posedge clk); #1;
    check({4'd0, q}, 8'(m_q), {tag, "_mid"});
    if (l)      m_q = (int'(lv) < MOD) ? int'(lv) : MOD - 1;
    else if (e) m_q = u ? (m_q + 1) % MOD : (m_q + MOD - 1) % MOD;
    @(negedge clk); #1;
    check({4'd0, q}, 8'(m_q), {tag, "_q"});
  endtask

  initial begin
    int c;
    // Power-on reset
    repeat (2) @(negedge clk);
    #1;
    check({4'd0, q}, 8'd0, "por_q");
    check({7'd0, tc}, 8'd0, "por_tc");
    rst_n = 1'b1;
    m_q = 0;

    // Up-count 12 cycles from 0: 1..9,0,1,2
    for (int unsigned i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 4'd0, "up");

    // Down-count from 2: 1,0,9,8
    step(1'b0, 1'b0, 1'b1, 4'd2, "ld2");
    for (int unsigned i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 4'd0, "down");

    // Load overrides enable; out-of-range load clamps
    step(1'b1, 1'b1, 1'b1, 4'd6, "ld6");
    step(1'b1, 1'b1, 1'b1, 4'd13, "ld13");
    step(1'b1, 1'b1, 1'b1, 4'd15, "ld15");

    // Hold at 4 for 5 cycles
    step(1'b0, 1'b0, 1'b1, 4'd4, "ld4");
    for (int unsigned i = 0; i < 5; i++) begin
      en = 1'b0; load = 1'b0; up = i[0];
      #1;
      check({4'd0, dut.j_vec | dut.k_vec}, 8'd0, "hold_jk");
      #1;
      step(1'b0, i[0], 1'b0, 4'd0, "hold");
    end

    // Reset pulse in the high phase with a pending increment
    step(1'b0, 1'b0, 1'b1, 4'd7, "ld7");
    en = 1'b1; up = 1'b1; load = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check({4'd0, q}, 8'd0, "rst_async_q");
    up = 1'b0;
    #1;
    check({7'd0, tc}, 8'd1, "rst_tc");
    rst_n = 1'b1;
    @(negedge clk); #1;
    check({4'd0, q}, 8'd0, "rst_release_q");
    m_q = 0;

    // Randomized traffic against the model
    for (int unsigned i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 7) == 0),
           4'($urandom_range(0, 15)), "rand");
    end

    // Cascade: 25 enabled cycles from 00
    en = 1'b0; load = 1'b0;
    cas_en = 1'b1;
    c = 0;
    for (int unsigned i = 0; i < 25; i++) begin
      @(negedge clk); #1;
      c++;
      check({4'd0, units_q}, 8'(c % 10), "cas_units");
      check({4'd0, tens_q}, 8'(c / 10), "cas_tens");
    end
    cas_en = 1'b0;
    #1;
    check({4'd0, tens_q, units_q} , {4'd0, 4'd2, 4'd5} , "cas_25");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/jk_mod_counter.md
Name: jk_mod_counter

Overview:
- Synchronous modulo-MOD up/down counter built from master-slave JK stages; default configuration is a BCD decade counter.
- Next-state logic produces the per-bit J/K drive that feeds the master-slave storage stages, so it is the stage directly upstream of the flip-flops.
- Used as the count and divide element for lab datapaths that cascade JK storage.

Parameters:
- WIDTH, 4, counter bit width.
- MOD, 10, count modulus. Legal range is 2 to 2**WIDTH. Elaboration-time error outside this range.

Ports:
- clk  input  1  clock; masters capture on rising edge, slaves update on falling edge
- rst_n  input  1  asynchronous active-low reset; clears masters and slaves
- en  input  1  count enable, sampled at the rising edge
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  synchronous parallel load, sampled at the rising edge; overrides en
- load_val  input  WIDTH  value to load
- q  output  WIDTH  current count (slave outputs)
- tc  output  1  terminal count, combinational

Behaviour:
- Reset:
  - rst_n low forces all masters and slaves to 0 immediately, without waiting for a clock.
  - While in reset: q = 0; tc = en & ~up.
  - Release is synchronous to the next rising edge. No pending operation survives reset.
- Timing:
  - Decisions are made at the rising edge (master capture).
  - q changes only at the following falling edge (slave transfer), half a cycle of latency.
  - Between those edges q holds its old value.
  - Next-state logic uses slave q only, so there is no race.
- Next value n, with priority top-down:
  - load=1: n = load_val if load_val < MOD, otherwise n = MOD-1 (clamp).
  - en=1, up=1: n = 0 if q == MOD-1, otherwise q+1.
  - en=1, up=0: n = MOD-1 if q == 0, otherwise q-1.
  - Otherwise: n = q (hold).
- JK drive per bit i:
  - Load cycle: J_i = n_i, K_i = ~n_i (set/reset mode).
  - Count or hold: J_i = K_i = q_i ^ n_i (toggle mode); hold gives J=K=0.
  - J=K=1 never occurs on a load cycle.
- Wrap-around:
  - Up from MOD-1 goes to 0.
  - Down from 0 goes to MOD-1.
  - Illegal states q >= MOD, reachable only when MOD < 2**WIDTH and after X/glitch, behave as follows:
    - Up goes to 0.
    - Down goes to MOD-1.
- tc:
  - tc = en & ((up & q == MOD-1) | (~up & q == 0)).
  - Independent of load.
  - Asserted during the cycle before the wrap, so cascaded counters can feed tc into the next stage's en.
- Simultaneous events:
  - load with en: load wins.
  - up/en changes between edges have effect only at the next rising edge.
  - Reset asserted between a rising edge and its falling edge: the pending master value is discarded and q = 0.

Decomposition:
- Shared package jk_pkg holds:
  - The jk_mode_e typedef (HOLD, RESET, SET, TOGGLE).
  - A function that encodes a JK pair into jk_mode_e, for use in coverage.
- One natural sub-module: jk_ms_stage, a single-bit master-slave JK with async active-low reset.
  - Ports: clk, rst_n, j, k, q.
  - Master updates on the rising edge per JK truth table; slave copies the master on the falling edge.
- jk_mod_counter instantiates WIDTH jk_ms_stage instances plus the next-state/JK logic.

Test Plan:
- Reset: drive counter to 7, pulse rst_n low mid-high-phase -> q = 0 within the reset assertion, before any clock edge; q stays 0 until the first falling edge after release.
- Up-count: en=1, up=1 for 12 cycles from 0 -> q sequence 1..9,0,1,2, each change at a falling edge; tc=1 exactly in the cycle where q=9.
- Down-count: en=1, up=0 from q=2 -> 1,0,9,8; tc=1 while q=0.
- Load:
  - load=1, load_val=6 with en=1, up=1 -> q=6 after the falling edge, no increment that cycle.
  - load_val=13 -> q=9 (clamp).
- Hold: en=0 for 5 cycles at q=4 -> q stays 4; all J/K = 0; tc = 0 regardless of up.
- Cascade: two instances, second's en = first's tc -> tens digit increments only on units 9->0; after 25 enabled cycles from 00 -> 25.
